regfile_write_arbiter: RTL

//  Shares the single register-file write port (RW/BusW/RegWr) between two writeback sources:
//  Src0 = execute/ALU result, Src1 = memory/load result (older instruction in the pipeline).

---
 rtl/regfile_write_arbiter_pkg.sv | 19 +
 rtl/regfile_write_arbiter_if.sv | 13 +
 rtl/regfile_write_arbiter_rr_arb2.sv | 35 +++
 rtl/regfile_write_arbiter.sv | 99 +++++++++
 4 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants, the buffered write-request type and a register decode helper
// for the register-file write arbiter.
package regfile_write_arbiter_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

  typedef struct packed {
    logic [ADDR_W-1:0] rw;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // One-hot mask of a register index, used to build the Pending vector.
  function automatic logic [31:0] regMask(input logic [ADDR_W-1:0] r);
    return 32'd1 << r;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request channel from one source (ALU or memory) into the arbiter.
interface regfile_write_arbiter_if;
  import regfile_write_arbiter_pkg::*;

  logic              Valid;
  logic              Ready;
  logic [ADDR_W-1:0] RW;
  logic [DATA_W-1:0] BusW;

  modport master (output Valid, output RW, output BusW, input Ready);
  modport slave  (input Valid, input RW, input BusW, output Ready);

endinterface

// File: rtl/regfile_write_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. When both requests target the same register the
// override hands the grant to requester 1 (the older instruction) regardless of
// the pointer, so the younger write lands last.
module rr_arb2 (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] req,
  input  logic       sameAddr,
  output logic [1:0] grant
);

  // High when requester 1 won most recently; resets high so requester 0 wins the first tie.
  logic lastWinner;

  // Pick a winner among the active requests.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (sameAddr || !lastWinner) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Every grant, including an override, moves the pointer to the winner.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      lastWinner <= 1'b1;
    end else if (|grant) begin
      lastWinner <= grant[1];
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between the ALU writeback (src0) and the
// load writeback (src1). Each source owns a one-entry buffer; buffered entries are
// arbitrated and the winner is registered onto RegWr/RW/BusW. Pending flags every
// register with a buffered or issuing write so decode can stall on it.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
(
  input  logic                     Clk,
  input  logic                     Reset,
  regfile_write_arbiter_if.slave   src0,
  regfile_write_arbiter_if.slave   src1,
  output logic                     RegWr,
  output logic [ADDR_W-1:0]        RW,
  output logic [DATA_W-1:0]        BusW,
  output logic [31:0]              Pending
);

  wb_req_t           buf0, buf1, buf0Nxt, buf1Nxt, winner;
  logic              full0, full1, full0Nxt, full1Nxt;
  logic              accept0, accept1, sameAddr;
  logic [1:0]        grant;
  logic              regWrNxt;
  logic [ADDR_W-1:0] rwNxt;
  logic [DATA_W-1:0] busWNxt;
  logic [31:0]       pendingNxt;

  assign sameAddr = (buf0.rw == buf1.rw);

  rr_arb2 u_arb (
    .Clk      (Clk),
    .Reset    (Reset),
    .req      ({full1, full0}),
    .sameAddr (sameAddr),
    .grant    (grant)
  );

  // A buffer that drains this cycle can refill on the same edge.
  assign src0.Ready = !full0 || grant[0];
  assign src1.Ready = !full1 || grant[1];

  // Next-state of buffers, output stage and pending mask.
  always_comb begin
    accept0 = src0.Valid && src0.Ready;
    accept1 = src1.Valid && src1.Ready;

    full0Nxt = full0;
    buf0Nxt  = buf0;
    if (grant[0]) full0Nxt = 1'b0;
    if (accept0) begin
      full0Nxt = 1'b1;
      buf0Nxt  = '{rw: src0.RW, data: src0.BusW};
    end

    full1Nxt = full1;
    buf1Nxt  = buf1;
    if (grant[1]) full1Nxt = 1'b0;
    if (accept1) begin
      full1Nxt = 1'b1;
      buf1Nxt  = '{rw: src1.RW, data: src1.BusW};
    end

    // Writes to the zero register are consumed here: index/data still move, enable stays low.
    winner   = grant[1] ? buf1 : buf0;
    regWrNxt = (|grant) && (winner.rw != ZERO_REG);
    rwNxt    = (|grant) ? winner.rw : RW;
    busWNxt  = (|grant) ? winner.data : BusW;

    // Computed from next state so the registered mask lines up with the buffers it describes.
    pendingNxt = 32'd0;
    if (full0Nxt) pendingNxt = pendingNxt | regMask(buf0Nxt.rw);
    if (full1Nxt) pendingNxt = pendingNxt | regMask(buf1Nxt.rw);
    if (regWrNxt) pendingNxt = pendingNxt | regMask(rwNxt);
    pendingNxt[ZERO_REG] = 1'b0;
  end

  // State update; reset drops any buffered or in-flight write.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      full0   <= 1'b0;
      full1   <= 1'b0;
      buf0    <= '0;
      buf1    <= '0;
      RegWr   <= 1'b0;
      RW      <= '0;
      BusW    <= '0;
      Pending <= '0;
    end else begin
      full0   <= full0Nxt;
      full1   <= full1Nxt;
      buf0    <= buf0Nxt;
      buf1    <= buf1Nxt;
      RegWr   <= regWrNxt;
      RW      <= rwNxt;
      BusW    <= busWNxt;
      Pending <= pendingNxt;
    end
  end

endmodule
